// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver with mid-bit sampling, optional parity,
// 1 or 2 stop bits and a one-entry valid/ready holding register.
// Parity mismatches, stop-bit framing errors and overruns are reported as
// one-cycle pulses.
module uart_rx #(
    parameter int ClockDivider = 8,
    parameter int DataBits     = 8,
    parameter int StopBits     = 1,
    parameter int Parity       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_bit,
    output logic [DataBits-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                busy,
    output logic                parity_error,
    output logic                frame_error,
    output logic                overrun
);

    localparam int ClockDivBits = $clog2(ClockDivider);
    localparam int IdxBits      = 4;
    localparam logic [ClockDivBits-1:0] HalfCount = ClockDivBits'(ClockDivider / 2 - 1);
    localparam logic [ClockDivBits-1:0] FullCount = ClockDivBits'(ClockDivider - 1);
    localparam logic [IdxBits-1:0]      LastData  = IdxBits'(DataBits - 1);
    localparam logic [IdxBits-1:0]      LastStop  = IdxBits'(StopBits - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    if (ClockDivider < 4) begin : g_bad_div
        $error("uart_rx: ClockDivider must be >= 4");
    end
    if (DataBits < 5 || DataBits > 9) begin : g_bad_data
        $error("uart_rx: DataBits must be in [5,9]");
    end
    if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
        $error("uart_rx: StopBits must be 1 or 2");
    end
    if (Parity < 0 || Parity > 2) begin : g_bad_par
        $error("uart_rx: Parity must be 0, 1 or 2");
    end

    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [2:0]              state_q, state_d;
    logic [ClockDivBits-1:0] cnt_q, cnt_d;
    logic [IdxBits-1:0]      bit_idx_q, bit_idx_d;
    logic [DataBits-1:0]     shift_q, shift_d;
    logic                    par_flag_q, par_flag_d;
    logic                    frm_flag_q, frm_flag_d;
    logic [DataBits-1:0]     data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    pe_q, pe_d;
    logic                    fe_q, fe_d;
    logic                    ov_q, ov_d;

    logic rx_s;
    logic frm_now;
    logic par_exp;

    assign rx_s    = sync2_q;
    assign frm_now = frm_flag_q | ~rx_s;
    // Even parity expects the bit to make the total count of ones even.
    assign par_exp = (Parity == 1) ? ^shift_q : ~^shift_q;

    // Next-state logic: synchroniser, bit-timing FSM, frame completion and holding register.
    always_comb begin
        sync1_d    = in_bit;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_flag_d = par_flag_q;
        frm_flag_d = frm_flag_q;
        data_d     = data_q;
        valid_d    = valid_q;
        pe_d       = 1'b0;
        fe_d       = 1'b0;
        ov_d       = 1'b0;

        // Consumer handshake; a frame completing this cycle may reload below.
        if (valid_q && data_out_ready) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d    = START;
                    par_flag_d = 1'b0;
                    frm_flag_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HalfCount) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FullCount) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DataBits-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LastData) begin
                        bit_idx_d = '0;
                        state_d   = (Parity != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == FullCount) begin
                    cnt_d      = '0;
                    par_flag_d = (rx_s != par_exp);
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FullCount) begin
                    cnt_d      = '0;
                    frm_flag_d = frm_now;
                    bit_idx_d  = bit_idx_q + 1'b1;
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (bit_idx_q == LastStop) begin
                        bit_idx_d = '0;
                        state_d   = IDLE;
                        if (frm_now) begin
                            fe_d = 1'b1;
                        end else if (par_flag_q) begin
                            pe_d = 1'b1;
                        end else if (!valid_q || data_out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; synchroniser resets to the idle line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_flag_q <= 1'b0;
            frm_flag_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_flag_q <= par_flag_d;
            frm_flag_q <= frm_flag_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign busy           = (state_q != IDLE);
    assign parity_error   = pe_q;
    assign frame_error    = fe_q;
    assign overrun        = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. DUT0 is 8N1, DUT1 is 8E1, both at
// 8 clocks per bit. Expected characters are queued when a frame is driven and
// popped whenever a DUT hands a character over (valid && ready).
module tb_uart_rx;
    localparam int DIV = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in0 = 1'b1, in1 = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1;
    logic [7:0] d0, d1;
    logic v0, v1, busy0, busy1, pe0, pe1, fe0, fe1, ov0, ov1;

    int errors = 0;
    int checks = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int vcyc0 = 0, rx0_n = 0, rx1_n = 0;
    int fe0_n = 0, pe0_n = 0, ov0_n = 0, pe1_n = 0, fe1_n = 0;
    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.ClockDivider(DIV), .DataBits(8), .StopBits(1), .Parity(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_bit(in0), .data_out(d0), .data_out_valid(v0),
        .data_out_ready(rdy0), .busy(busy0), .parity_error(pe0), .frame_error(fe0),
        .overrun(ov0)
    );

    uart_rx #(.ClockDivider(DIV), .DataBits(8), .StopBits(1), .Parity(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_bit(in1), .data_out(d1), .data_out_valid(v1),
        .data_out_ready(rdy1), .busy(busy1), .parity_error(pe1), .frame_error(fe1),
        .overrun(ov1)
    );

    // Scoreboard monitor: pops expected characters on each handshake, counts pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (v0) vcyc0++;
            if (fe0) fe0_n++;
            if (pe0) pe0_n++;
            if (ov0) ov0_n++;
            if (pe1) pe1_n++;
            if (fe1) fe1_n++;
            if (v0 && rdy0) begin
                checks++;
                rx0_n++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL sb0_unexpected: got %h, expected none", d0);
                end else begin
                    logic [7:0] e;
                    e = q0.pop_front();
                    if (d0 !== e) begin
                        errors++;
                        $display("FAIL sb0_data: got %h, expected %h", d0, e);
                    end
                end
            end
            if (v1 && rdy1) begin
                checks++;
                rx1_n++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb1_unexpected: got %h, expected none", d1);
                end else begin
                    logic [7:0] e;
                    e = q1.pop_front();
                    if (d1 !== e) begin
                        errors++;
                        $display("FAIL sb1_data: got %h, expected %h", d1, e);
                    end
                end
            end
        end
    end

    // Random ready for the bulk test; low at most a few cycles in a row in practice.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 rdy0 = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drive(input bit sel, input bit v);
        if (sel) in1 = v; else in0 = v;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit par_en,
                        input bit par, input bit stop);
        drive(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive(sel, d[i]);
        if (par_en) drive(sel, par);
        drive(sel, stop);
    endtask

    task automatic set_rdy0(input bit v);
        @(posedge clk);
        #1 rdy0 = v;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", v0); end
        checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h, expected 00", d0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy0); end
        checks++; if ({pe0, fe0, ov0} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b, expected 000", {pe0, fe0, ov0}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int vc, fe, pe, ov, rn;
        vc = vcyc0; fe = fe0_n; pe = pe0_n; ov = ov0_n; rn = rx0_n;
        q0.push_back(8'hA5);
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx0_n - rn !== 1) begin errors++; $display("FAIL basic_count: got %0d, expected 1", rx0_n - rn); end
        checks++; if (vcyc0 - vc !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d, expected 1", vcyc0 - vc); end
        checks++; if ((fe0_n - fe) + (pe0_n - pe) + (ov0_n - ov) !== 0) begin errors++; $display("FAIL basic_pulses: got %0d, expected 0", (fe0_n - fe) + (pe0_n - pe) + (ov0_n - ov)); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b, expected 0", busy0); end
    endtask

    task automatic test_glitch;
        int vc, fe;
        bit seen_busy;
        vc = vcyc0; fe = fe0_n; seen_busy = 0;
        in0 = 1'b0;
        repeat (2) @(negedge clk);
        in0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy0) seen_busy = 1;
        end
        checks++; if (seen_busy !== 1'b1) begin errors++; $display("FAIL glitch_start_seen: got %b, expected 1", seen_busy); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b, expected 0", busy0); end
        checks++; if ((vcyc0 - vc) + (fe0_n - fe) !== 0) begin errors++; $display("FAIL glitch_outputs: got %0d events, expected 0", (vcyc0 - vc) + (fe0_n - fe)); end
    endtask

    task automatic test_frame_error;
        int vc, fe, rn;
        vc = vcyc0; fe = fe0_n; rn = rx0_n;
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        in0 = 1'b1;
        repeat (16) @(negedge clk);
        checks++; if (fe0_n - fe !== 1) begin errors++; $display("FAIL frame_error_pulse: got %0d, expected 1", fe0_n - fe); end
        checks++; if (vcyc0 - vc !== 0) begin errors++; $display("FAIL frame_error_valid: got %0d cycles, expected 0", vcyc0 - vc); end
        q0.push_back(8'h12);
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx0_n - rn !== 1) begin errors++; $display("FAIL frame_error_recover: got %0d, expected 1", rx0_n - rn); end
    endtask

    task automatic test_parity;
        int pe, rn, fe;
        pe = pe1_n; rn = rx1_n; fe = fe1_n;
        send(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (pe1_n - pe !== 1) begin errors++; $display("FAIL parity_error_pulse: got %0d, expected 1", pe1_n - pe); end
        checks++; if (rx1_n - rn !== 0) begin errors++; $display("FAIL parity_bad_valid: got %0d, expected 0", rx1_n - rn); end
        q1.push_back(8'h01);
        send(1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx1_n - rn !== 1) begin errors++; $display("FAIL parity_good: got %0d, expected 1", rx1_n - rn); end
        checks++; if ((pe1_n - pe) + (fe1_n - fe) !== 1) begin errors++; $display("FAIL parity_pulses: got %0d, expected 1", (pe1_n - pe) + (fe1_n - fe)); end
    endtask

    task automatic test_overrun;
        int ov;
        ov = ov0_n;
        set_rdy0(1'b0);
        @(negedge clk);
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (ov0_n - ov !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d, expected 1", ov0_n - ov); end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b, expected 1", v0); end
        checks++; if (d0 !== 8'h11) begin errors++; $display("FAIL overrun_data: got %h, expected 11", d0); end
        q0.push_back(8'h11);
        set_rdy0(1'b1);
        repeat (2) @(negedge clk);
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL overrun_drain: got valid %b, expected 0", v0); end
    endtask

    task automatic test_back_to_back;
        int rn, ov;
        rn = rx0_n; ov = ov0_n;
        rand_rdy = 1'b1;
        for (int b = 0; b < 256; b++) begin
            q0.push_back(8'(b));
            send(1'b0, 8'(b), 1'b0, 1'b0, 1'b1);
        end
        rand_rdy = 1'b0;
        set_rdy0(1'b1);
        repeat (20) @(negedge clk);
        checks++; if (rx0_n - rn !== 256) begin errors++; $display("FAIL b2b_count: got %0d, expected 256", rx0_n - rn); end
        checks++; if (q0.size() !== 0) begin errors++; $display("FAIL b2b_leftover: got %0d, expected 0", q0.size()); end
        checks++; if (ov0_n - ov !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d, expected 0", ov0_n - ov); end
    endtask

    task automatic test_reset_midframe;
        int rn;
        // Leave a character stranded in the holding register first.
        set_rdy0(1'b0);
        @(negedge clk);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b, expected 1", v0); end
        in0 = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b, expected 1", busy0); end
        #1 rst = 1'b1;
        #1;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, expected 0", v0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy0); end
        in0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdy0 = 1'b1;
        repeat (4) @(negedge clk);
        rn = rx0_n;
        q0.push_back(8'h77);
        send(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (rx0_n - rn !== 1) begin errors++; $display("FAIL rstmid_next: got %0d, expected 1", rx0_n - rn); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_parity;
        test_overrun;
        test_back_to_back;
        test_reset_midframe;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always reaches its summary.
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
